// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address field helpers for the
// direct-mapped, write-through cache controller.
package cache_pkg;

   localparam int TAG_W          = 3;
   localparam int INDEX_W        = 5;
   localparam int OFFSET_W       = 2;
   localparam int WORDS_PER_LINE = 4;
   localparam int DATA_W         = 32;
   localparam int ADDR_W         = 10;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      READ_HIT,
      REFILL,
      WRITE_MEM,
      RESP
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU, cache-array and memory signals of the cache controller.
// master: the surrounding system (CPU, array, memory); slave: the controller.
interface cache_controller_if;
   import cache_pkg::*;

   logic              cpu_rd;
   logic              cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_ready;

   logic [TAG_W:0]    tag_valid;
   logic [ADDR_W-1:0] cache_addr;
   logic [DATA_W-1:0] cache_datain;
   logic              hit;
   logic              update_cache;

   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, tag_valid, mem_rdata, mem_ready,
      output cpu_stall, cpu_ready, cache_addr, cache_datain, hit, update_cache,
             mem_rd, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, tag_valid, mem_rdata, mem_ready,
      input  cpu_stall, cpu_ready, cache_addr, cache_datain, hit, update_cache,
             mem_rd, mem_wr, mem_addr, mem_wdata
   );

endinterface

// File: rtl/cache_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module cache_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // count register, cleared by async reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end

   // advance only while below the ceiling
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
   end

   assign count = count_q;

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped cache controller: read-allocate with 4-word line refill,
// write-through / no-write-allocate on writes.
// Optional hit/miss statistics: define CACHE_CTRL_STATS_EN.
//
// state     | meaning
// IDLE      | waiting for cpu_rd/cpu_wr, request latched on acceptance
// COMPARE   | tag check of the indexed line; write hit updates the array here
// READ_HIT  | one-cycle array read strobe
// REFILL    | fetch the 4 words of the line from memory into the array
// WRITE_MEM | write-through to memory, held until mem_ready
// RESP      | one-cycle cpu_ready, array data valid for reads
module cache_controller
   import cache_pkg::*;
(
   input  logic clk,
   input  logic rst,
   cache_controller_if.slave bus
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  is_wr_q, is_wr_d;
   logic [OFFSET_W-1:0]   cnt_q, cnt_d;
   logic                  line_hit;
   logic [ADDR_W-1:0]     refill_addr;

   assign line_hit    = bus.tag_valid[TAG_W] && (bus.tag_valid[TAG_W-1:0] == addr_tag(addr_q));
   assign refill_addr = {addr_q[ADDR_W-1:OFFSET_W], cnt_q};

   // state and request registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         cnt_q   <= cnt_d;
      end
   end

   // next-state and request capture
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.cpu_rd || bus.cpu_wr) begin
               addr_d  = bus.cpu_addr;
               wdata_d = bus.cpu_wdata;
               is_wr_d = !bus.cpu_rd;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (is_wr_q)       state_d = WRITE_MEM;
            else if (line_hit) state_d = READ_HIT;
            else begin
               state_d = REFILL;
               cnt_d   = '0;
            end
         end
         READ_HIT: state_d = RESP;
         REFILL: begin
            if (bus.mem_ready) begin
               cnt_d = cnt_q + OFFSET_W'(1);
               // last word in: re-check, which now hits
               if (cnt_q == OFFSET_W'(WORDS_PER_LINE-1)) state_d = COMPARE;
            end
         end
         WRITE_MEM: if (bus.mem_ready) state_d = RESP;
         RESP:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Moore/Mealy outputs, all zero in IDLE
   always_comb begin
      bus.cpu_stall    = 1'b0;
      bus.cpu_ready    = 1'b0;
      bus.cache_addr   = '0;
      bus.cache_datain = '0;
      bus.hit          = 1'b0;
      bus.update_cache = 1'b0;
      bus.mem_rd       = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      case (state_q)
         COMPARE: begin
            bus.cpu_stall  = 1'b1;
            bus.cache_addr = addr_q;
            if (is_wr_q && line_hit) begin
               bus.update_cache = 1'b1;
               bus.cache_datain = wdata_q;
            end
         end
         READ_HIT: begin
            bus.cpu_stall  = 1'b1;
            bus.cache_addr = addr_q;
            bus.hit        = 1'b1;
         end
         REFILL: begin
            bus.cpu_stall  = 1'b1;
            bus.cache_addr = refill_addr;
            bus.mem_rd     = 1'b1;
            bus.mem_addr   = refill_addr;
            if (bus.mem_ready) begin
               bus.update_cache = 1'b1;
               bus.cache_datain = bus.mem_rdata;
            end
         end
         WRITE_MEM: begin
            bus.cpu_stall  = 1'b1;
            bus.cache_addr = addr_q;
            bus.mem_wr     = 1'b1;
            bus.mem_addr   = addr_q;
            bus.mem_wdata  = wdata_q;
         end
         RESP: begin
            bus.cpu_stall  = 1'b1;
            bus.cache_addr = addr_q;
            bus.cpu_ready  = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef CACHE_CTRL_STATS_EN
   // first_q marks the first COMPARE of a request so the post-refill
   // re-compare is not counted a second time
   logic first_q, first_d;
   logic hit_inc, miss_inc;

   // first-compare flag register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) first_q <= 1'b0;
      else      first_q <= first_d;
   end

   // set on acceptance, cleared once the first decision is taken
   always_comb begin
      first_d = first_q;
      if (state_q == IDLE && (bus.cpu_rd || bus.cpu_wr)) first_d = 1'b1;
      else if (state_q == COMPARE)                       first_d = 1'b0;
   end

   assign hit_inc  = (state_q == COMPARE) && first_q && line_hit;
   assign miss_inc = (state_q == COMPARE) && first_q && !line_hit;

   cache_sat_counter #(.W(16)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   cache_sat_counter #(.W(16)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache array and main memory around
// the DUT, expected read data queued at request time and checked at cpu_ready.
module tb_cache_controller;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cache_controller_if bus();

`ifdef CACHE_CTRL_STATS_EN
   logic [15:0] hit_count, miss_count;
   logic        sat_inc;
   logic [15:0] sat_count;
`endif

   cache_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef CACHE_CTRL_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

`ifdef CACHE_CTRL_STATS_EN
   cache_sat_counter #(.W(16)) u_sat (
      .clk   (clk),
      .rst   (rst),
      .inc   (sat_inc),
      .count (sat_count)
   );
`endif

   int errors = 0;
   int checks = 0;

   // cache array model: tag/valid readout is combinational on cache_addr
   logic [31:0] arr_data [32][4];
   logic        arr_valid[32];
   logic [2:0]  arr_tag  [32];

   assign bus.tag_valid = {arr_valid[bus.cache_addr[6:2]], arr_tag[bus.cache_addr[6:2]]};

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) arr_valid[i] <= 1'b0;
      end else if (bus.update_cache) begin
         arr_data[bus.cache_addr[6:2]][bus.cache_addr[1:0]] <= bus.cache_datain;
         arr_valid[bus.cache_addr[6:2]] <= 1'b1;
         arr_tag[bus.cache_addr[6:2]]   <= bus.cache_addr[9:7];
      end
   end

   // main memory model with programmable ready latency
   logic [31:0] mem_model[1024];
   logic        mem_inited = 1'b0;
   logic        force_ready = 1'b0;
   int          mem_delay = 0;
   int          wait_cnt = 0;

   assign bus.mem_ready = force_ready || ((bus.mem_rd || bus.mem_wr) && (wait_cnt >= mem_delay));
   assign bus.mem_rdata = mem_model[bus.mem_addr];

   always @(posedge clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < 1024; i++) mem_model[i] <= 32'hC0DE_0000 | 32'(i);
         mem_inited <= 1'b1;
      end else if (bus.mem_wr && bus.mem_ready) begin
         mem_model[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   always @(posedge clk) begin
      if (bus.mem_rd || bus.mem_wr) wait_cnt <= bus.mem_ready ? 0 : wait_cnt + 1;
      else                          wait_cnt <= 0;
   end

   // reference state and per-request observations
   logic [31:0] gold[1024];
   logic [31:0] exp_q[$];
   logic [9:0]  exp_wr_addr = '0;
   logic [31:0] exp_wr_data = '0;
   logic [9:0]  rlog[4];
   logic [31:0] last_upd;
   int d_lat, d_words, d_rdc, d_wrc, d_upd, d_hit;

   task automatic do_req(input logic rd, input logic wr, input logic [9:0] addr,
                         input logic [31:0] data);
      logic [31:0] exp, act;
      logic        got;
      d_lat = 0; d_words = 0; d_rdc = 0; d_wrc = 0; d_upd = 0; d_hit = 0; got = 1'b0;
      last_upd = '0;
      @(negedge clk);
      bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = data;
      if (rd) exp_q.push_back(gold[addr]);
      else begin
         gold[addr] = data; exp_wr_addr = addr; exp_wr_data = data;
      end
      while (!got && d_lat < 60) begin
         @(negedge clk);
         d_lat++;
         if (d_lat == 1) begin bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; end
         checks++;
         if ((bus.hit && bus.update_cache) || (bus.mem_rd && bus.mem_wr))
            begin errors++; $display("FAIL exclusive_strobes: hit=%b upd=%b mem_rd=%b mem_wr=%b required no pair high",
                                     bus.hit, bus.update_cache, bus.mem_rd, bus.mem_wr); end
         if (bus.mem_rd) d_rdc++;
         if (bus.mem_rd && bus.mem_ready) begin
            if (d_words < 4) rlog[d_words] = bus.mem_addr;
            d_words++;
            checks++;
            if (!bus.update_cache || bus.cache_datain !== bus.mem_rdata || bus.cache_addr !== bus.mem_addr)
               begin errors++; $display("FAIL refill_write: upd=%b datain=%h addr=%h required 1 %h %h",
                                        bus.update_cache, bus.cache_datain, bus.cache_addr, bus.mem_rdata, bus.mem_addr); end
         end
         if (bus.update_cache) begin d_upd++; last_upd = bus.cache_datain; end
         if (bus.hit) d_hit++;
         if (bus.mem_wr) begin
            d_wrc++;
            checks++;
            if (bus.mem_addr !== exp_wr_addr || bus.mem_wdata !== exp_wr_data)
               begin errors++; $display("FAIL mem_wr_hold: addr=%h data=%h required %h %h",
                                        bus.mem_addr, bus.mem_wdata, exp_wr_addr, exp_wr_data); end
         end
         if (bus.cpu_ready) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++; $display("FAIL cpu_ready_timeout: addr=%h got no cpu_ready in %0d cycles", addr, d_lat);
         if (rd) exp = exp_q.pop_front();
      end else if (rd) begin
         exp = exp_q.pop_front();
         act = arr_data[bus.cache_addr[6:2]][bus.cache_addr[1:0]];
         checks++;
         if (act !== exp || bus.cache_addr !== addr)
            begin errors++; $display("FAIL read_data: addr=%h data=%h required addr=%h data=%h",
                                     bus.cache_addr, act, addr, exp); end
      end
   endtask

   task automatic test_reset();
      bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.cpu_stall, bus.cpu_ready, bus.cache_addr, bus.cache_datain, bus.hit, bus.update_cache,
           bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== '0)
         begin errors++; $display("FAIL reset_outputs: stall=%b ready=%b mem_rd=%b required all zero",
                                  bus.cpu_stall, bus.cpu_ready, bus.mem_rd); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_stall: %b required 0", bus.cpu_stall); end
   endtask

   task automatic test_cold_read();
      mem_delay = 0;
      do_req(1'b1, 1'b0, 10'h085, '0);
      checks++;
      if (d_lat != 8 || d_words != 4 || d_upd != 4 || d_hit != 1)
         begin errors++; $display("FAIL cold_read_counts: lat=%0d words=%0d upd=%0d hit=%0d required 8 4 4 1",
                                  d_lat, d_words, d_upd, d_hit); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rlog[k] !== 10'h084 + 10'(k))
            begin errors++; $display("FAIL refill_addr%0d: %h required %h", k, rlog[k], 10'h084 + 10'(k)); end
      end
   endtask

   task automatic test_hit_read();
      force_ready = 1'b1;
      do_req(1'b1, 1'b0, 10'h086, '0);
      force_ready = 1'b0;
      checks++;
      if (d_lat != 3 || d_rdc != 0 || d_hit != 1 || d_upd != 0)
         begin errors++; $display("FAIL hit_read: lat=%0d mem_rd=%0d hit=%0d upd=%0d required 3 0 1 0",
                                  d_lat, d_rdc, d_hit, d_upd); end
   endtask

   task automatic test_write_hit();
      mem_delay = 3;
      do_req(1'b0, 1'b1, 10'h086, 32'hDEAD_BEEF);
      checks++;
      if (d_lat != 6 || d_wrc != 4 || d_upd != 1 || last_upd !== 32'hDEAD_BEEF)
         begin errors++; $display("FAIL write_hit: lat=%0d wr=%0d upd=%0d data=%h required 6 4 1 deadbeef",
                                  d_lat, d_wrc, d_upd, last_upd); end
      checks++;
      if (mem_model[10'h086] !== 32'hDEAD_BEEF)
         begin errors++; $display("FAIL write_through: %h required deadbeef", mem_model[10'h086]); end
`ifdef CACHE_CTRL_STATS_EN
      checks++;
      if (hit_count !== 16'd2 || miss_count !== 16'd1)
         begin errors++; $display("FAIL stats: hit=%0d miss=%0d required 2 1", hit_count, miss_count); end
`endif
      mem_delay = 0;
      do_req(1'b1, 1'b0, 10'h086, '0);
      checks++;
      if (d_lat != 3 || d_rdc != 0)
         begin errors++; $display("FAIL read_after_write: lat=%0d mem_rd=%0d required 3 0", d_lat, d_rdc); end
   endtask

   task automatic test_write_miss();
      mem_delay = 0;
      do_req(1'b0, 1'b1, 10'h3FC, 32'h1234_5678);
      checks++;
      if (d_lat != 3 || d_wrc != 1 || d_upd != 0)
         begin errors++; $display("FAIL write_miss: lat=%0d wr=%0d upd=%0d required 3 1 0", d_lat, d_wrc, d_upd); end
      do_req(1'b1, 1'b0, 10'h3FC, '0);
      checks++;
      if (d_words != 4 || d_lat != 8 || rlog[0] !== 10'h3FC)
         begin errors++; $display("FAIL miss_refill: words=%0d lat=%0d first=%h required 4 8 3fc",
                                  d_words, d_lat, rlog[0]); end
   endtask

   task automatic test_rd_wins();
      do_req(1'b1, 1'b1, 10'h087, 32'hFFFF_0000);
      checks++;
      if (d_wrc != 0 || d_upd != 0 || d_lat != 3)
         begin errors++; $display("FAIL rd_priority: wr=%0d upd=%0d lat=%0d required 0 0 3", d_wrc, d_upd, d_lat); end
   endtask

   task automatic test_reset_mid_refill();
      int w;
      logic found;
      w = 0; found = 1'b0;
      mem_delay = 2;
      @(negedge clk);
      bus.cpu_rd = 1'b1; bus.cpu_addr = 10'h200;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (k == 0) bus.cpu_rd = 1'b0;
         if (bus.mem_rd && bus.mem_ready) w++;
         else if (w == 1 && bus.mem_rd) found = 1'b1;
      end
      checks++;
      if (!found || bus.mem_addr !== 10'h201)
         begin errors++; $display("FAIL second_word: found=%b addr=%h required 1 201", found, bus.mem_addr); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({bus.cpu_stall, bus.cpu_ready, bus.cache_addr, bus.cache_datain, bus.hit, bus.update_cache,
           bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== '0)
         begin errors++; $display("FAIL async_reset: stall=%b mem_rd=%b mem_addr=%h required all zero",
                                  bus.cpu_stall, bus.mem_rd, bus.mem_addr); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      mem_delay = 0;
      do_req(1'b1, 1'b0, 10'h200, '0);
      checks++;
      if (d_words != 4 || d_lat != 8 || rlog[0] !== 10'h200 || rlog[3] !== 10'h203)
         begin errors++; $display("FAIL restart_refill: words=%0d lat=%0d first=%h last=%h required 4 8 200 203",
                                  d_words, d_lat, rlog[0], rlog[3]); end
   endtask

`ifdef CACHE_CTRL_STATS_EN
   task automatic test_saturation();
      @(negedge clk);
      sat_inc = 1'b1;
      repeat (65535) @(negedge clk);
      checks++;
      if (sat_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: %h required ffff", sat_count); end
      repeat (5) @(negedge clk);
      sat_inc = 1'b0;
      checks++;
      if (sat_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: %h required ffff", sat_count); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) gold[i] = 32'hC0DE_0000 | 32'(i);
`ifdef CACHE_CTRL_STATS_EN
      sat_inc = 1'b0;
`endif
      test_reset();
      test_cold_read();
      test_hit_read();
      test_write_hit();
      test_write_miss();
      test_rd_wins();
      test_reset_mid_refill();
`ifdef CACHE_CTRL_STATS_EN
      test_saturation();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
